// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - control unit <-> datapath / instruction memory signal bundle
interface cpu_ctrl_if;
    logic        start;
    logic [15:0] ins;
    logic        dp_done;
    logic        en_ram_out;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [7:0]  offset;
    logic        en_in_rf;
    logic [3:0]  reg_en;
    logic        alu_in_sel;
    logic [3:0]  alu_func;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        busy;
    logic        halted;
    logic        err;

    // controller side
    modport master (
        input  start, ins, dp_done,
        output en_ram_out, en_pc_pulse, pc_ctrl, offset_addr, offset, en_in_rf,
               reg_en, alu_in_sel, alu_func, rd, rs, busy, halted, err
    );

    // datapath / memory / host side
    modport slave (
        output start, ins, dp_done,
        input  en_ram_out, en_pc_pulse, pc_ctrl, offset_addr, offset, en_in_rf,
               reg_en, alu_in_sel, alu_func, rd, rs, busy, halted, err
    );
endinterface

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle fetch/decode/execute control unit
module cpu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    cpu_ctrl_if.master  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_WAIT   = 4'd5,
        S_WB     = 4'd6,
        S_PC_UPD = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            err_q, err_d;

    // Outputs are decoded from the next state and registered, so every
    // strobe is glitch-free and lines up exactly with its state.
    logic            en_ram_q, en_ram_d;
    logic            en_pc_q, en_pc_d;
    logic [1:0]      pc_ctrl_q, pc_ctrl_d;
    logic            en_in_rf_q, en_in_rf_d;
    logic [3:0]      reg_en_q, reg_en_d;
    logic            alu_in_sel_q, alu_in_sel_d;
    logic [3:0]      alu_func_q, alu_func_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

    logic [3:0]      op;

    assign op      = ir_q[15:12];
    assign cnt_inc = cnt_q + CW'(1);

    // Next-state logic and next values of the registered Moore outputs
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        en_ram_d     = 1'b0;
        en_pc_d      = 1'b0;
        pc_ctrl_d    = 2'b00;
        en_in_rf_d   = 1'b0;
        reg_en_d     = 4'b0000;
        alu_in_sel_d = 1'b0;
        alu_func_d   = 4'd0;
        busy_d       = 1'b0;
        halted_d     = 1'b0;

        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_LOAD;
            S_LOAD: begin
                ir_d    = bus.ins;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7:       state_d = S_EXEC;
                    4'h0, 4'h8:             state_d = S_PC_UPD;
                    4'hF:                   state_d = S_HALT;
                    default: begin
                        // illegal opcode: flag it, then carry on as a NOP
                        err_d   = 1'b1;
                        state_d = S_PC_UPD;
                    end
                endcase
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // completion on the last allowed cycle still counts as success
                if (bus.dp_done) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_WB:     state_d = S_PC_UPD;
            S_PC_UPD: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        case (ir_d[15:12])
            4'h1: alu_func_d = 4'd1;
            4'h2: alu_func_d = 4'd2;
            4'h3: alu_func_d = 4'd3;
            4'h4: alu_func_d = 4'd4;
            4'h5: alu_func_d = 4'd5;
            4'h6: begin alu_func_d = 4'd1; alu_in_sel_d = 1'b1; end
            4'h7: begin alu_func_d = 4'd6; alu_in_sel_d = 1'b1; end
            default: begin alu_func_d = 4'd0; alu_in_sel_d = 1'b0; end
        endcase

        en_ram_d   = (state_d == S_FETCH);
        en_in_rf_d = (state_d == S_EXEC);
        en_pc_d    = (state_d == S_PC_UPD);
        if (state_d == S_WB)
            reg_en_d = 4'b0001 << ir_d[11:10];
        if (state_d == S_PC_UPD)
            pc_ctrl_d = (ir_d[15:12] == 4'h8) ? 2'b10 : 2'b01;
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    // State, instruction register, wait counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ir_q         <= 16'h0000;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            en_ram_q     <= 1'b0;
            en_pc_q      <= 1'b0;
            pc_ctrl_q    <= 2'b00;
            en_in_rf_q   <= 1'b0;
            reg_en_q     <= 4'b0000;
            alu_in_sel_q <= 1'b0;
            alu_func_q   <= 4'd0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            en_ram_q     <= en_ram_d;
            en_pc_q      <= en_pc_d;
            pc_ctrl_q    <= pc_ctrl_d;
            en_in_rf_q   <= en_in_rf_d;
            reg_en_q     <= reg_en_d;
            alu_in_sel_q <= alu_in_sel_d;
            alu_func_q   <= alu_func_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.en_ram_out  = en_ram_q;
    assign bus.en_pc_pulse = en_pc_q;
    assign bus.pc_ctrl     = pc_ctrl_q;
    assign bus.offset_addr = ir_q[7:0];
    assign bus.offset      = ir_q[7:0];
    assign bus.en_in_rf    = en_in_rf_q;
    assign bus.reg_en      = reg_en_q;
    assign bus.alu_in_sel  = alu_in_sel_q;
    assign bus.alu_func    = alu_func_q;
    assign bus.rd          = ir_q[11:10];
    assign bus.rs          = ir_q[9:8];
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - directed self-checking bench for cpu_ctrl
module tb_cpu_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   dp_delay;
    int   dp_cnt;

    int   n_cyc, rf_at, rf_cnt, we_at, we_cnt, pc_at, pc_cnt, halt_at, err_at, stray_pc;
    logic [3:0] we_val;
    logic [1:0] pc_val;

    cpu_ctrl_if bus ();

    cpu_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath model: dp_done pulses dp_delay cycles after en_in_rf (0 = never)
    initial begin
        bus.dp_done = 1'b0;
        dp_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                dp_cnt = 0;
                bus.dp_done = 1'b0;
            end else begin
                if (dp_cnt > 0) begin
                    dp_cnt = dp_cnt - 1;
                    bus.dp_done = (dp_cnt == 0);
                end else begin
                    bus.dp_done = 1'b0;
                end
                if (bus.en_in_rf && dp_delay > 0) dp_cnt = dp_delay;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Entered with the DUT in FETCH (cycle 1); records strobe timing until the
    // next FETCH or HALT, bounded to 48 cycles.
    task automatic run_instr(input logic [15:0] instr, input int delay);
        bus.ins = instr;
        dp_delay = delay;
        n_cyc = 0; rf_at = 0; rf_cnt = 0; we_at = 0; we_cnt = 0; we_val = 4'h0;
        pc_at = 0; pc_cnt = 0; pc_val = 2'b00; halt_at = 0; err_at = 0; stray_pc = 0;
        for (int c = 1; c <= 48; c++) begin
            if (c > 1 && bus.en_ram_out) begin
                n_cyc = c - 1;
                break;
            end
            if (bus.en_in_rf) begin rf_cnt++; if (rf_at == 0) rf_at = c; end
            if (bus.reg_en != 4'h0) begin we_cnt++; we_at = c; we_val = bus.reg_en; end
            if (bus.en_pc_pulse) begin pc_cnt++; pc_at = c; pc_val = bus.pc_ctrl; end
            else if (bus.pc_ctrl != 2'b00) stray_pc++;
            if (bus.err && err_at == 0) err_at = c;
            if (bus.halted) begin halt_at = c; break; end
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.halted, bus.err, bus.en_ram_out, bus.en_pc_pulse, bus.en_in_rf,
             bus.reg_en, bus.pc_ctrl, bus.alu_in_sel, bus.alu_func, bus.rd, bus.rs,
             bus.offset, bus.offset_addr} !== 37'h0) begin
            errors++; $display("FAIL reset_outputs: got busy=%b en_ram=%b err=%b expected all zero",
                               bus.busy, bus.en_ram_out, bus.err);
        end
        rst = 1'b0;
        step(); step();
        checks++;
        if ({bus.busy, bus.en_ram_out} !== 2'b00) begin
            errors++; $display("FAIL idle_without_start: got busy=%b en_ram=%b expected 0 0",
                               bus.busy, bus.en_ram_out);
        end
    endtask

    task automatic test_add();
        do_start();
        checks++;
        if ({bus.en_ram_out, bus.busy} !== 2'b11) begin
            errors++; $display("FAIL start_fetch: got en_ram=%b busy=%b expected 1 1", bus.en_ram_out, bus.busy);
        end
        run_instr(16'h1600, 3);
        checks++;
        if (n_cyc !== 9) begin errors++; $display("FAIL add_latency: got %0d expected 9", n_cyc); end
        checks++;
        if (rf_at !== 4 || rf_cnt !== 1) begin
            errors++; $display("FAIL add_en_in_rf: got cycle %0d count %0d expected cycle 4 count 1", rf_at, rf_cnt);
        end
        checks++;
        if (we_at !== 8 || we_cnt !== 1 || we_val !== 4'b0010) begin
            errors++; $display("FAIL add_reg_en: got cycle %0d count %0d val %b expected 8 1 0010", we_at, we_cnt, we_val);
        end
        checks++;
        if (pc_at !== 9 || pc_cnt !== 1 || pc_val !== 2'b01 || stray_pc !== 0) begin
            errors++; $display("FAIL add_pc_update: got cycle %0d count %0d ctrl %b stray %0d expected 9 1 01 0",
                               pc_at, pc_cnt, pc_val, stray_pc);
        end
        checks++;
        if ({bus.alu_func, bus.alu_in_sel, bus.rd, bus.rs} !== {4'd1, 1'b0, 2'd1, 2'd2}) begin
            errors++; $display("FAIL add_fields: got func=%0d sel=%b rd=%0d rs=%0d expected 1 0 1 2",
                               bus.alu_func, bus.alu_in_sel, bus.rd, bus.rs);
        end
    endtask

    task automatic test_movi();
        run_instr(16'h7C5A, 3);
        checks++;
        if ({bus.offset, bus.alu_in_sel, bus.alu_func, bus.rd} !== {8'h5A, 1'b1, 4'd6, 2'd3}) begin
            errors++; $display("FAIL movi_fields: got offset=%h sel=%b func=%0d rd=%0d expected 5a 1 6 3",
                               bus.offset, bus.alu_in_sel, bus.alu_func, bus.rd);
        end
        checks++;
        if (n_cyc !== 9 || we_val !== 4'b1000 || we_cnt !== 1) begin
            errors++; $display("FAIL movi_writeback: got cyc=%0d reg_en=%b count=%0d expected 9 1000 1",
                               n_cyc, we_val, we_cnt);
        end
    endtask

    task automatic test_jmp();
        run_instr(16'h8042, 3);
        checks++;
        if (n_cyc !== 4 || rf_cnt !== 0 || we_cnt !== 0) begin
            errors++; $display("FAIL jmp_sequence: got cyc=%0d en_in_rf=%0d reg_en=%0d expected 4 0 0",
                               n_cyc, rf_cnt, we_cnt);
        end
        checks++;
        if (pc_at !== 4 || pc_val !== 2'b10 || bus.offset_addr !== 8'h42 || bus.alu_func !== 4'd0) begin
            errors++; $display("FAIL jmp_pc: got cycle %0d ctrl %b addr %h func %0d expected 4 10 42 0",
                               pc_at, pc_val, bus.offset_addr, bus.alu_func);
        end
    endtask

    task automatic test_illegal_halt();
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL err_before_illegal: got %b expected 0", bus.err); end
        run_instr(16'hA000, 3);
        checks++;
        if (n_cyc !== 4 || pc_val !== 2'b01 || rf_cnt !== 0 || err_at !== 4) begin
            errors++; $display("FAIL illegal_as_nop: got cyc=%0d ctrl=%b rf=%0d err_at=%0d expected 4 01 0 4",
                               n_cyc, pc_val, rf_cnt, err_at);
        end
        run_instr(16'hF000, 3);
        checks++;
        if (halt_at !== 4 || bus.busy !== 1'b0 || bus.err !== 1'b1) begin
            errors++; $display("FAIL halt_reach: got halt_at=%0d busy=%b err=%b expected 4 0 1",
                               halt_at, bus.busy, bus.err);
        end
        bus.start = 1'b1;
        step(); step();
        bus.start = 1'b0;
        step();
        checks++;
        if ({bus.halted, bus.busy, bus.err, bus.en_ram_out} !== 4'b1010) begin
            errors++; $display("FAIL halt_sticky: got halted=%b busy=%b err=%b en_ram=%b expected 1 0 1 0",
                               bus.halted, bus.busy, bus.err, bus.en_ram_out);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        checks++;
        if ({bus.err, bus.halted} !== 2'b00) begin
            errors++; $display("FAIL reset_clears_err: got err=%b halted=%b expected 0 0", bus.err, bus.halted);
        end
        do_start();
        run_instr(16'h1600, 0);
        checks++;
        if (halt_at !== 21 || err_at !== 21 || we_cnt !== 0 || rf_cnt !== 1) begin
            errors++; $display("FAIL timeout: got halt_at=%0d err_at=%0d reg_en=%0d rf=%0d expected 21 21 0 1",
                               halt_at, err_at, we_cnt, rf_cnt);
        end
    endtask

    task automatic test_done_on_last_cycle();
        apply_reset();
        do_start();
        run_instr(16'h1600, 16);
        checks++;
        if (n_cyc !== 22 || we_at !== 21 || err_at !== 0 || halt_at !== 0) begin
            errors++; $display("FAIL done_on_timeout_cycle: got cyc=%0d we_at=%0d err_at=%0d halt_at=%0d expected 22 21 0 0",
                               n_cyc, we_at, err_at, halt_at);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        do_start();
        bus.ins = 16'h1600;
        dp_delay = 0;
        repeat (5) step();
        checks++;
        if ({bus.busy, bus.en_ram_out, bus.rd} !== {1'b1, 1'b0, 2'd1}) begin
            errors++; $display("FAIL in_wait_before_reset: got busy=%b en_ram=%b rd=%0d expected 1 0 1",
                               bus.busy, bus.en_ram_out, bus.rd);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.halted, bus.err, bus.en_ram_out, bus.en_pc_pulse, bus.en_in_rf,
             bus.reg_en, bus.pc_ctrl, bus.alu_in_sel, bus.alu_func, bus.rd, bus.rs,
             bus.offset, bus.offset_addr} !== 37'h0) begin
            errors++; $display("FAIL async_reset: got busy=%b rd=%0d func=%0d expected all zero",
                               bus.busy, bus.rd, bus.alu_func);
        end
        step();
        rst = 1'b0;
        do_start();
        run_instr(16'h1600, 3);
        checks++;
        if (n_cyc !== 9 || rf_at !== 4 || we_at !== 8 || we_val !== 4'b0010 || pc_val !== 2'b01) begin
            errors++; $display("FAIL rerun_after_reset: got cyc=%0d rf=%0d we=%0d val=%b ctrl=%b expected 9 4 8 0010 01",
                               n_cyc, rf_at, we_at, we_val, pc_val);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        dp_delay = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ins = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_movi();
        test_jmp();
        test_illegal_halt();
        test_timeout();
        test_done_on_last_cycle();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Multi-cycle control unit that sequences the single-issue datapath (PC, 4-entry register file, ALU operand mux, ALU).
- Fetches a 16-bit instruction from synchronous instruction memory, decodes it, and drives the datapath control fields.
- Waits on the datapath completion strobe, commits the register write, then updates the PC.
- Sits beside the datapath in the CPU top; the instruction memory address is the datapath pc_out.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT for dp_done before the block flags an error and halts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin execution from IDLE; ignored in every other state.
- ins  in  16  instruction memory read data; valid the cycle after en_ram_out.
- dp_done  in  1  datapath ALU completion strobe (ALU en_out).
- en_ram_out  out  1  instruction memory read enable.
- en_pc_pulse  out  1  one-cycle PC update strobe.
- pc_ctrl  out  2  PC operation: 00 hold, 01 increment, 10 load offset_addr.
- offset_addr  out  8  jump target (ir[7:0]).
- offset  out  8  immediate operand (ir[7:0]).
- en_in_rf  out  1  one-cycle strobe that starts the register read / ALU chain.
- reg_en  out  4  one-hot register write enable, indexed by rd.
- alu_in_sel  out  1  ALU B select: 0 rs_q, 1 offset.
- alu_func  out  4  ALU operation code.
- rd  out  2  destination / A-source register (ir[11:10]).
- rs  out  2  B-source register (ir[9:8]).
- busy  out  1  high from leaving IDLE until HALT is reached.
- halted  out  1  high in HALT.
- err  out  1  sticky; set on illegal opcode or timeout; cleared only by rst.

Behaviour:
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr. The IR latches ins in LOAD. rd, rs, offset and offset_addr are driven from the IR and hold stable from DECODE until the next LOAD.
- Opcodes and alu_func values:
  - 0 NOP.
  - 1 ADD, func 1.
  - 2 SUB, func 2.
  - 3 AND, func 3.
  - 4 OR, func 4.
  - 5 XOR, func 5.
  - 6 ADDI, func 1, sel 1.
  - 7 MOVI, func 6 (pass B), sel 1.
  - 8 JMP.
  - F HALT.
  - 9–E illegal: set err, then execute as NOP.
- ALU ops use alu_in_sel=0 unless marked sel 1. alu_func=0 and alu_in_sel=0 for non-ALU ops.
- FSM states: IDLE, FETCH, LOAD, DECODE, EXEC, WAIT, WB, PC_UPD, HALT.
  - IDLE -> FETCH when start=1.
  - FETCH: en_ram_out=1 for one cycle -> LOAD.
  - LOAD: ir<=ins -> DECODE.
  - DECODE: ALU op -> EXEC; NOP/JMP/illegal -> PC_UPD; HALT -> HALT.
  - EXEC: en_in_rf=1 for one cycle -> WAIT. dp_done is not sampled in EXEC.
  - WAIT: dp_done=1 -> WB. Otherwise increment the wait counter; when the counter reaches TIMEOUT, set err -> HALT.
  - WB: reg_en = one-hot(rd) for one cycle -> PC_UPD.
  - PC_UPD: en_pc_pulse=1 for one cycle. pc_ctrl=10 for JMP, 01 otherwise -> FETCH.
  - HALT: terminal; exits only on rst.
- pc_ctrl is 00 in every state except PC_UPD. All strobes are exactly one cycle wide and registered (Moore outputs).
- Latency:
  - ALU instruction = 6 + k cycles, where k = WAIT cycles including the dp_done cycle (k=3 with the nominal datapath).
  - NOP/JMP = 4 cycles.
  - HALT reaches the HALT state 3 cycles after FETCH.
- Wait counter clears on entry to WAIT. A dp_done arriving on the TIMEOUT-th cycle wins over the timeout.
- Reset (any state, including mid-instruction): state=IDLE, ir=0, all outputs 0, err=0, busy=0, halted=0, wait counter=0. Because the reset is asynchronous, any strobe in flight is deasserted immediately.
- Spurious dp_done outside WAIT is ignored.

Test Plan:
- Reset, start=1, ins=16'h1600 (ADD r1,r2) with dp_done 3 cycles after en_in_rf -> en_in_rf pulse in cycle 4, reg_en=4'b0010 one cycle, alu_func=1, alu_in_sel=0, then en_pc_pulse with pc_ctrl=01; total 9 cycles FETCH-to-FETCH.
- ins=16'h7C5A (MOVI r3,0x5A) -> offset=8'h5A, alu_in_sel=1, alu_func=6, reg_en=4'b1000.
- ins=16'h8042 (JMP 0x42) -> no en_in_rf or reg_en; en_pc_pulse with pc_ctrl=10 and offset_addr=8'h42, 4 cycles after FETCH.
- ins=16'hA000 (illegal) -> err=1, behaves as NOP (pc_ctrl=01), execution continues; next ins=16'hF000 -> halted=1, busy=0, stays halted with start pulsed; err remains 1.
- ADD with dp_done never asserted, TIMEOUT=16 -> after 16 WAIT cycles err=1, halted=1, no reg_en pulse.
- rst asserted in the middle of WAIT, then the same program restarted with start -> all outputs 0 immediately on rst, state IDLE; re-execution matches the first scenario.
